// File: rtl/rf_pkg.sv
// Shared constants and types for the regfile write-back path.
// Imported by the arbiter and the top-level write-port owner.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NREG     = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// The pointer moves only when both requesters contend.
module rr_arb2 #(
    parameter bit ALU_FIRST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    import rf_pkg::*;

    localparam req_e PtrRst = ALU_FIRST ? REQ_ALU : REQ_LSU;

    req_e ptr_q, ptr_d;
    logic both;

    always_comb begin
        both  = req_i[REQ_ALU] & req_i[REQ_LSU];
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (both) begin
            // Winner is the favoured side; favour the loser next time.
            if (ptr_q == REQ_ALU) begin
                gnt_o[REQ_ALU] = 1'b1;
                ptr_d          = REQ_LSU;
            end else begin
                gnt_o[REQ_LSU] = 1'b1;
                ptr_d          = REQ_ALU;
            end
        end else if (req_i[REQ_ALU]) begin
            gnt_o[REQ_ALU] = 1'b1;
        end else if (req_i[REQ_LSU]) begin
            gnt_o[REQ_LSU] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PtrRst;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the regfile write port: arbitrates ALU/LSU write-backs into
// a registered write stage and tracks pending writes per register.
module regfile_wb_arbiter #(
    parameter int XLEN      = rf_pkg::XLEN,
    parameter int AW        = rf_pkg::AW,
    parameter int NREG      = rf_pkg::NREG,
    parameter bit ALU_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data_in,
    output logic [NREG-1:0] busy
);
    import rf_pkg::*;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            acc;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;

    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [NREG-1:0] busy_q, busy_d;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_LSU] = lsu_valid;

    rr_arb2 #(
        .ALU_FIRST (ALU_FIRST)
    ) u_arb (
        .clk_i  (clk),
        .rst_ni (rst),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    // Ready is masked while reset is held so nothing is handed off.
    assign alu_ready = gnt[REQ_ALU] & rst;
    assign lsu_ready = gnt[REQ_LSU] & rst;
    assign acc       = |gnt;

    always_comb begin
        win_addr = alu_addr;
        win_data = alu_data;
        if (gnt[REQ_LSU]) begin
            win_addr = lsu_addr;
            win_data = lsu_data;
        end
    end

    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (acc) begin
            addr_d = win_addr;
            data_d = win_data;
            we_d   = (win_addr != AW'(REG_ZERO));
        end
    end

    // Set after clear: a newer producer outranks the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != AW'(REG_ZERO))) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign rf_we         = we_q;
    assign rf_rd_addr    = addr_q;
    assign rf_rd_data_in = data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a tiny regfile model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_addr, lsu_addr, issue_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data_in;
    logic [31:0] busy;

    logic [31:0] mem [32];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .lsu_valid     (lsu_valid),
        .lsu_addr      (lsu_addr),
        .lsu_data      (lsu_data),
        .lsu_ready     (lsu_ready),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rf_we         (rf_we),
        .rf_rd_addr    (rf_rd_addr),
        .rf_rd_data_in (rf_rd_data_in),
        .busy          (busy)
    );

    always @(posedge clk) begin
        if (rf_we) mem[rf_rd_addr] <= rf_rd_data_in;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1; issue_valid = 1'b0;
        alu_addr = 5'd1; lsu_addr = 5'd2; issue_rd = 5'd0;
        alu_data = 32'h1; lsu_data = 32'h2;
        #12;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_addr", {27'd0, rf_rd_addr}, 32'd0);
        check("rst_data", rf_rd_data_in, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_alu_rdy", {31'd0, alu_ready}, 32'd0);
        check("rst_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // ALU-only write of 0xDEADBEEF to x5
        nedge();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("t1_alu_rdy", {31'd0, alu_ready}, 32'd1);
        check("t1_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
        nedge();
        alu_valid = 1'b0;
        check("t1_we", {31'd0, rf_we}, 32'd1);
        check("t1_addr", {27'd0, rf_rd_addr}, 32'd5);
        check("t1_data", rf_rd_data_in, 32'hDEADBEEF);
        nedge();
        check("t1_we_off", {31'd0, rf_we}, 32'd0);
        check("t1_rf_rd", mem[5], 32'hDEADBEEF);

        // Contention: ALU x3 vs LSU x4, ALU favoured first
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA0;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_alu_rdy%0d", i), {31'd0, alu_ready},
                  (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t2_lsu_rdy%0d", i), {31'd0, lsu_ready},
                  (i % 2 == 0) ? 32'd0 : 32'd1);
            nedge();
            check($sformatf("t2_we%0d", i), {31'd0, rf_we}, 32'd1);
            check($sformatf("t2_addr%0d", i), {27'd0, rf_rd_addr},
                  (i % 2 == 0) ? 32'd3 : 32'd4);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        nedge();
        check("t2_rf_x3", mem[3], 32'hA0);
        check("t2_rf_x4", mem[4], 32'hB0);

        // Scoreboard set on issue, clear on the write edge
        issue_valid = 1'b1; issue_rd = 5'd7;
        nedge();
        issue_valid = 1'b0;
        check("t3_busy_set", busy, 32'h0000_0080);
        nedge();
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        nedge();
        alu_valid = 1'b0;
        check("t3_we", {31'd0, rf_we}, 32'd1);
        check("t3_busy_hold", busy, 32'h0000_0080);
        nedge();
        check("t3_busy_clr", busy, 32'd0);

        // Same-edge clear and re-issue of x9: set wins
        issue_valid = 1'b1; issue_rd = 5'd9;
        nedge();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        nedge();
        alu_valid = 1'b0;
        check("t4_we", {31'd0, rf_we}, 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd9;
        nedge();
        issue_valid = 1'b0;
        check("t4_busy_keep", busy, 32'h0000_0200);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9A;
        nedge();
        alu_valid = 1'b0;
        nedge();
        check("t4_busy_clr", busy, 32'd0);

        // x0 request and x0 issue
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h12345678;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("t5_lsu_rdy", {31'd0, lsu_ready}, 32'd1);
        nedge();
        lsu_valid = 1'b0; issue_valid = 1'b0;
        check("t5_we", {31'd0, rf_we}, 32'd0);
        check("t5_busy", busy, 32'd0);

        // Reset mid-write with busy = x7|x8 and pointer moved to LSU
        issue_valid = 1'b1; issue_rd = 5'd7;
        nedge();
        issue_rd = 5'd8;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h55;
        lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h66;
        #1;
        check("t6_alu_win", {31'd0, alu_ready}, 32'd1);
        nedge();
        issue_valid = 1'b0;
        alu_addr = 5'd10;
        check("t6_pre_we", {31'd0, rf_we}, 32'd1);
        check("t6_pre_busy", busy, 32'h0000_0180);
        check("t6_ptr_lsu", {31'd0, lsu_ready}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_we", {31'd0, rf_we}, 32'd0);
        check("t6_rst_busy", busy, 32'd0);
        check("t6_rst_alu", {31'd0, alu_ready}, 32'd0);
        check("t6_rst_lsu", {31'd0, lsu_ready}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("t6_ptr_alu", {31'd0, alu_ready}, 32'd1);
        check("t6_ptr_lsu0", {31'd0, lsu_ready}, 32'd0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        nedge();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of `regfile` (`we`/`rd_addr`/`rd_data_in`) and shares it between two write-back requesters: ALU and load/store unit (LSU).
- Round-robin arbitration with a valid/ready handshake.
- Registered output stage drives the regfile.
- Per-register pending-write scoreboard (`busy`) for the decode hazard logic.

Parameters:
- XLEN, 32, data width of the regfile write port.
- AW, 5, register address width.
- NREG, 32, number of architectural registers (2**AW).
- ALU_FIRST, 1, initial round-robin priority after reset (1 = ALU, 0 = LSU).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU write-back request.
- lsu_addr  in  AW  LSU destination register.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- issue_valid  in  1  instruction with destination issued this cycle.
- issue_rd  in  AW  its destination register.
- rf_we  out  1  to `regfile` `we`.
- rf_rd_addr  out  AW  to `regfile` `rd_addr`.
- rf_rd_data_in  out  XLEN  to `regfile` `rd_data_in`.
- busy  out  NREG  bit i = write to register i pending.

Behaviour:
- **Reset (`rst` = 0, asynchronous):**
  - rf_we = 0, rf_rd_addr = 0, rf_rd_data_in = 0, busy = 0.
  - Priority pointer = ALU_FIRST.
  - alu_ready = lsu_ready = 0 while reset is held.
- **Arbitration (combinational):**
  - Only one valid: that requester is granted.
  - Both valid: the requester the pointer favours is granted; the other sees ready = 0.
  - Ready is never asserted without valid.
  - The regfile never back-pressures, so one request is accepted every cycle that any request is valid.
- **Pointer:**
  - Updates only on a contended grant (both valid), to favour the loser next time.
  - An uncontended grant leaves the pointer unchanged.
  - Guarantee: a continuously-valid requester waits at most 1 cycle.
- **Handshake:**
  - A requester holds valid, addr and data stable until its ready is seen.
  - Accept happens at the edge where valid & ready = 1.
- **Output stage:**
  - On accept at edge N: rf_rd_addr/rf_rd_data_in load the winner's values, and rf_we = 1 during cycle N+1 when addr != 0.
  - The regfile commits at edge N+1. Latency is request-accept to regfile-write = 1 cycle.
  - No accept at edge N: rf_we = 0 in cycle N+1; addr/data hold their previous values.
- **x0 handling:**
  - Requests with addr 0 are accepted (ready = 1) but produce rf_we = 0.
  - issue_valid with issue_rd = 0 is ignored.
  - busy[0] is constant 0.
- **Scoreboard:**
  - Set: busy[issue_rd] <= 1 at the edge when issue_valid = 1.
  - Clear: busy[rf_rd_addr] <= 0 at the edge when rf_we = 1, i.e. the same edge the regfile writes. busy = 0 therefore implies the regfile holds final data.
  - Set and clear of the same register on the same edge: set wins (newer producer outstanding).
  - Different registers update independently in the same cycle.
- **Reset mid-operation:** an in-flight registered write is dropped (rf_we forced 0) and all busy bits clear. The pipeline flushes on reset.
- No forwarding is provided; the consumer stalls while busy is set.

Decomposition:
- Shared package `rf_pkg`:
  - constants XLEN, AW, NREG.
  - localparam REG_ZERO = 0.
  - requester-index encoding REQ_ALU = 0, REQ_LSU = 1.
- Sub-module `rr_arb2`: 2-input round-robin arbiter holding the pointer flop.
- Output register and scoreboard stay in the top module.

Test Plan:
- ALU only, addr 5, data 0xDEADBEEF, 1 cycle → alu_ready = 1 that cycle. Next cycle rf_we = 1, rf_rd_addr = 5, rf_rd_data_in = 0xDEADBEEF. Regfile rs1_addr = 5 then reads 0xDEADBEEF.
- ALU and LSU both valid for 4 cycles from reset (ALU_FIRST = 1), addrs 3/4 → grants ALU, LSU, ALU, LSU. rf_rd_addr sequence is 3, 4, 3, 4 with rf_we continuously 1.
- issue_valid, issue_rd = 7, then ALU write to 7 two cycles later → busy[7] rises the edge after issue. It falls at the edge where rf_we = 1 with rf_rd_addr = 7.
- Same-edge conflict: rf_we = 1 for reg 9 while issue_valid issues rd = 9 → busy[9] stays 1.
- x0 request: LSU valid, addr 0, data 0x12345678, plus issue_rd = 0 → lsu_ready = 1, rf_we stays 0, busy[0] = 0.
- Reset mid-write: assert rst = 0 asynchronously while rf_we = 1 and busy = 0x00000180 → rf_we = 0 and busy = 0 immediately without a clock edge. After release the pointer = ALU.
